// File: rtl/hyperbus_phy_frontend.sv
// rtl/hyperbus_phy_frontend.sv - HyperBus PHY front end: quad-phase clocks, CA encoder, DDR read capture
// Sits between the PHY transaction FSM and the pads; all widths are fixed.

module hyperbus_phy_frontend (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        clk0_o,
  output logic        clk90_o,
  output logic        clk180_o,
  output logic        clk270_o,
  input  logic        rw_i,
  input  logic        address_space_i,
  input  logic        burst_type_i,
  input  logic [31:0] address_i,
  output logic [47:0] cmd_addr_o,
  input  logic        hyper_rwds_i_d,
  input  logic [7:0]  hyper_dq_i,
  input  logic        enable_i,
  output logic [15:0] data_o
);

  logic       clk0_q;
  logic       clk90_q;
  logic [7:0] dq_hi_q;
  logic [7:0] dq_lo_q;

  // clk0 toggles on rising edges, clk90 on falling edges: quarter-period spacing at f/2
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk0_q <= 1'b0;
    end else begin
      clk0_q <= ~clk0_q;
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk90_q <= 1'b0;
    end else begin
      clk90_q <= ~clk90_q;
    end
  end

  assign clk0_o   = clk0_q;
  assign clk90_o  = clk90_q;
  assign clk180_o = ~clk0_q;
  assign clk270_o = ~clk90_q;

  // Column address bits [15:3] are reserved and driven low
  always_comb begin
    cmd_addr_o        = '0;
    cmd_addr_o[47]    = rw_i;
    cmd_addr_o[46]    = address_space_i;
    cmd_addr_o[45]    = burst_type_i;
    cmd_addr_o[44:16] = address_i[31:3];
    cmd_addr_o[2:0]   = address_i[2:0];
  end

  // First byte of each pair arrives with the rising strobe edge
  always_ff @(posedge hyper_rwds_i_d or posedge rst_i) begin
    if (rst_i) begin
      dq_hi_q <= 8'h00;
    end else begin
      dq_hi_q <= hyper_dq_i;
    end
  end

  always_ff @(negedge hyper_rwds_i_d or posedge rst_i) begin
    if (rst_i) begin
      dq_lo_q <= 8'h00;
    end else begin
      dq_lo_q <= hyper_dq_i;
    end
  end

  // Strobe-domain bytes are assumed stable by the next clk0 edge after the pair completes
  always_ff @(posedge clk0_q or posedge rst_i) begin
    if (rst_i) begin
      data_o <= 16'h0000;
    end else if (enable_i) begin
      data_o <= {dq_hi_q, dq_lo_q};
    end
  end

endmodule

// File: tb/tb_hyperbus_phy_frontend.sv
// tb/tb_hyperbus_phy_frontend.sv - directed self-checking bench for hyperbus_phy_frontend

module tb_hyperbus_phy_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clk0_o, clk90_o, clk180_o, clk270_o;
  logic        rw_i, address_space_i, burst_type_i;
  logic [31:0] address_i;
  logic [47:0] cmd_addr_o;
  logic        hyper_rwds_i_d;
  logic [7:0]  hyper_dq_i;
  logic        enable_i;
  logic [15:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  hyperbus_phy_frontend dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clk0_o          (clk0_o),
    .clk90_o         (clk90_o),
    .clk180_o        (clk180_o),
    .clk270_o        (clk270_o),
    .rw_i            (rw_i),
    .address_space_i (address_space_i),
    .burst_type_i    (burst_type_i),
    .address_i       (address_i),
    .cmd_addr_o      (cmd_addr_o),
    .hyper_rwds_i_d  (hyper_rwds_i_d),
    .hyper_dq_i      (hyper_dq_i),
    .enable_i        (enable_i),
    .data_o          (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk0_rise(input string tag);
    logic seen;
    logic prev;
    seen = 1'b0;
    prev = clk0_o;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (clk0_o === 1'b1 && prev === 1'b0) seen = 1'b1;
      prev = clk0_o;
    end
    check({tag, "_clk0_rise"}, {47'd0, seen}, 48'd1);
  endtask

  task automatic send_pair(input logic [7:0] first, input logic [7:0] second);
    hyper_dq_i     = first;
    #1 hyper_rwds_i_d = 1'b1;
    #2 hyper_dq_i  = second;
    #1 hyper_rwds_i_d = 1'b0;
    #1;
  endtask

  task automatic ca(input string tag, input logic rw, input logic sp, input logic bt,
                    input logic [31:0] addr, input logic [47:0] exp);
    rw_i = rw; address_space_i = sp; burst_type_i = bt; address_i = addr;
    #1;
    check(tag, cmd_addr_o, exp);
  endtask

  logic exp0, exp90;

  initial begin
    rst_i = 1'b1;
    rw_i = 1'b0; address_space_i = 1'b0; burst_type_i = 1'b0; address_i = '0;
    hyper_rwds_i_d = 1'b0; hyper_dq_i = 8'h00; enable_i = 1'b0;

    #22;
    check("rst_clk0",   {47'd0, clk0_o},   48'd0);
    check("rst_clk90",  {47'd0, clk90_o},  48'd0);
    check("rst_clk180", {47'd0, clk180_o}, 48'd1);
    check("rst_clk270", {47'd0, clk270_o}, 48'd1);
    check("rst_data",   {32'd0, data_o},   48'h0);

    @(negedge clk_i); #2;
    rst_i = 1'b0;
    exp0 = 1'b0; exp90 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      exp0 = ~exp0;
      check($sformatf("clk0_c%0d", c),   {47'd0, clk0_o},   {47'd0, exp0});
      check($sformatf("clk180_c%0d", c), {47'd0, clk180_o}, {47'd0, ~exp0});
      check($sformatf("clk90_hold_c%0d", c), {47'd0, clk90_o}, {47'd0, exp90});
      @(negedge clk_i); #1;
      exp90 = ~exp90;
      check($sformatf("clk90_c%0d", c),  {47'd0, clk90_o},  {47'd0, exp90});
      check($sformatf("clk270_c%0d", c), {47'd0, clk270_o}, {47'd0, ~exp90});
    end

    ca("ca_read",     1'b1, 1'b0, 1'b1, 32'h12345678, 48'hA2468ACF0000);
    ca("ca_write",    1'b0, 1'b0, 1'b1, 32'h00000007, 48'h200000000007);
    ca("ca_reg",      1'b1, 1'b1, 1'b1, 32'h00000000, 48'hE00000000000);
    ca("ca_wrap",     1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 48'h1FFFFFFF0007);
    ca("ca_lowbits",  1'b0, 1'b0, 1'b0, 32'h00000008, 48'h000000010000);

    @(posedge clk_i); #1;
    enable_i = 1'b1;
    send_pair(8'hAB, 8'hCD);
    wait_clk0_rise("ddr1");
    check("ddr_abcd", {32'd0, data_o}, 48'hABCD);
    send_pair(8'h12, 8'h34);
    wait_clk0_rise("ddr2");
    check("ddr_1234", {32'd0, data_o}, 48'h1234);
    wait_clk0_rise("ddr_idle");
    check("ddr_no_toggle", {32'd0, data_o}, 48'h1234);

    send_pair(8'h55, 8'h66);
    wait_clk0_rise("gate1");
    check("gate_5566", {32'd0, data_o}, 48'h5566);
    enable_i = 1'b0;
    send_pair(8'h77, 8'h88);
    wait_clk0_rise("gate2");
    wait_clk0_rise("gate3");
    check("gate_hold", {32'd0, data_o}, 48'h5566);
    enable_i = 1'b1;
    wait_clk0_rise("gate4");
    check("gate_7788", {32'd0, data_o}, 48'h7788);

    hyper_dq_i = 8'h9A;
    #1 hyper_rwds_i_d = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_data",   {32'd0, data_o},   48'h0);
    check("mid_rst_clk0",   {47'd0, clk0_o},   48'd0);
    check("mid_rst_clk90",  {47'd0, clk90_o},  48'd0);
    check("mid_rst_clk180", {47'd0, clk180_o}, 48'd1);
    check("mid_rst_clk270", {47'd0, clk270_o}, 48'd1);
    hyper_dq_i = 8'hBC;
    #1 hyper_rwds_i_d = 1'b0;
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_clk0",  {47'd0, clk0_o},  48'd1);
    check("post_rst_clk90", {47'd0, clk90_o}, 48'd0);
    check("post_rst_data",  {32'd0, data_o},  48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
